// File: rtl/iic_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus-level constants.
package iic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_DATA,
      WR_ACK,
      RD_DATA,
      RD_ACK,
      IGNORE
   } iic_slv_state_t;

   localparam logic IIC_RW_WRITE = 1'b0;
   localparam logic IIC_RW_READ  = 1'b1;
   localparam logic IIC_ACK      = 1'b0;
   localparam logic IIC_NACK     = 1'b1;

endpackage

// File: rtl/iic_bus_monitor.sv
// Synchronizes SCL/SDA into the clk domain and flags clock edges plus START/STOP conditions.
module iic_bus_monitor (
   input  logic clk,
   input  logic reset,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   // Bits [1:0] are the synchronizer, bit [2] is the delayed copy for edge detection.
   logic [2:0] scl_sync_q;
   logic [2:0] sda_sync_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_sync_q <= 3'b111;
         sda_sync_q <= 3'b111;
      end else begin
         scl_sync_q <= {scl_sync_q[1:0], scl_i};
         sda_sync_q <= {sda_sync_q[1:0], sda_i};
      end
   end

   assign sda      = sda_sync_q[1];
   assign scl_rise = scl_sync_q[1] & ~scl_sync_q[2];
   assign scl_fall = ~scl_sync_q[1] & scl_sync_q[2];
   assign start    = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
   assign stop     = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];

endmodule

// File: rtl/iic_slave_regs.sv
// I2C target with an NREG-byte register bank: first written byte sets the pointer,
// later bytes are stored; reads stream bytes from the pointer with wrap-around.
module iic_slave_regs
   import iic_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h54,
   parameter int unsigned NREG       = 8,
   parameter int unsigned PW         = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scl_i,
   input  logic              sda_i,
   output logic              scl_o,
   output logic              scl_t,
   output logic              sda_o,
   output logic              sda_t,
   output logic              wr_valid,
   output logic [PW-1:0]     wr_addr,
   output logic [7:0]        wr_data,
   output logic [NREG*8-1:0] regs,
   output logic              busy
);

   logic sda, scl_rise, scl_fall, start, stop;

   iic_bus_monitor u_bus_monitor (
      .clk      (clk),
      .reset    (reset),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   iic_slv_state_t state_q, state_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic           sda_t_q, sda_t_d;
   logic           busy_q, busy_d;
   logic [PW-1:0]  ptr_q, ptr_d;
   logic           first_q, first_d;
   logic           rw_q, rw_d;
   logic           wr_valid_q, wr_valid_d;
   logic [PW-1:0]  wr_addr_q, wr_addr_d;
   logic [7:0]     wr_data_q, wr_data_d;
   logic [7:0]     mem_q [NREG];
   logic [7:0]     rd_byte;
   logic           addr_match;

   assign rd_byte    = mem_q[ptr_q];
   // General call (0x00) is never claimed, even if SLAVE_ADDR were set to zero.
   assign addr_match = (shift_q[7:1] == SLAVE_ADDR) && (shift_q[7:1] != 7'h00);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      sda_t_d    = sda_t_q;
      busy_d     = busy_q;
      ptr_d      = ptr_q;
      first_d    = first_q;
      rw_d       = rw_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;

      // START outranks STOP so a glitch asserting both still opens a transfer.
      if (start) begin
         state_d   = ADDR;
         bit_cnt_d = 4'd0;
         sda_t_d   = 1'b1;
         busy_d    = 1'b0;
      end else if (stop) begin
         state_d = IDLE;
         sda_t_d = 1'b1;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE, IGNORE: begin
               sda_t_d = 1'b1;
            end
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  bit_cnt_d = 4'd0;
                  rw_d      = shift_q[0];
                  if (addr_match) begin
                     state_d = ADDR_ACK;
                     sda_t_d = IIC_ACK;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  busy_d = 1'b1;
                  if (rw_q == IIC_RW_WRITE) begin
                     state_d   = WR_DATA;
                     sda_t_d   = 1'b1;
                     first_d   = 1'b1;
                     bit_cnt_d = 4'd0;
                  end else begin
                     state_d   = RD_DATA;
                     shift_d   = rd_byte;
                     sda_t_d   = rd_byte[7];
                     bit_cnt_d = 4'd1;
                  end
               end
            end
            WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d   = WR_ACK;
                  sda_t_d   = IIC_ACK;
                  bit_cnt_d = 4'd0;
                  if (first_q) begin
                     ptr_d   = shift_q[PW-1:0];
                     first_d = 1'b0;
                  end else begin
                     wr_valid_d = 1'b1;
                     wr_addr_d  = ptr_q;
                     wr_data_d  = shift_q;
                     ptr_d      = ptr_q + PW'(1);
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  state_d = WR_DATA;
                  sda_t_d = 1'b1;
               end
            end
            RD_DATA: begin
               // bit_cnt counts bits already placed on SDA.
               if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d = RD_ACK;
                     sda_t_d = 1'b1;
                     ptr_d   = ptr_q + PW'(1);
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     sda_t_d   = shift_q[6];
                     bit_cnt_d = bit_cnt_q + 4'd1;
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise && sda == IIC_NACK) begin
                  state_d = IGNORE;
                  sda_t_d = 1'b1;
               end else if (scl_fall) begin
                  state_d   = RD_DATA;
                  shift_d   = rd_byte;
                  sda_t_d   = rd_byte[7];
                  bit_cnt_d = 4'd1;
               end
            end
            default: begin
               state_d = IDLE;
               sda_t_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'd0;
         sda_t_q    <= 1'b1;
         busy_q     <= 1'b0;
         ptr_q      <= '0;
         first_q    <= 1'b0;
         rw_q       <= IIC_RW_WRITE;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= 8'd0;
         for (int i = 0; i < NREG; i++) begin
            mem_q[i] <= 8'd0;
         end
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         sda_t_q    <= sda_t_d;
         busy_q     <= busy_d;
         ptr_q      <= ptr_d;
         first_q    <= first_d;
         rw_q       <= rw_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         if (wr_valid_d) begin
            mem_q[ptr_q] <= shift_q;
         end
      end
   end

   always_comb begin
      regs = '0;
      for (int i = 0; i < NREG; i++) begin
         regs[8*i +: 8] = mem_q[i];
      end
   end

   assign scl_o    = 1'b0;
   assign scl_t    = 1'b1;
   assign sda_o    = 1'b0;
   assign sda_t    = sda_t_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_iic_slave_regs.sv
// Bit-banged I2C master driving iic_slave_regs, with a register/pointer model and write scoreboard.
module tb_iic_slave_regs;
   import iic_pkg::*;

   localparam int Q = 200;  // quarter SCL period in ns (20 clk)

   logic        clk;
   logic        reset;
   logic        scl_m, sda_m;
   logic        scl_bus, sda_bus;
   logic        scl_o, scl_t, sda_o, sda_t;
   logic        wr_valid;
   logic [2:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [63:0] regs;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [2:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        exp_wr[$];
   logic [7:0] exp_rd[$];
   logic [7:0] m_regs[8];
   logic [2:0] m_ptr;
   logic       pulled;

   assign scl_bus = scl_m & (scl_t | scl_o);
   assign sda_bus = sda_m & (sda_t | sda_o);

   iic_slave_regs dut (
      .clk      (clk),
      .reset    (reset),
      .scl_i    (scl_bus),
      .sda_i    (sda_bus),
      .scl_o    (scl_o),
      .scl_t    (scl_t),
      .sda_o    (sda_o),
      .sda_t    (sda_t),
      .wr_valid (wr_valid),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .regs     (regs),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every wr_valid cycle must match the oldest expected write.
   always @(negedge clk) begin
      if (reset && wr_valid) begin
         n_checks++;
         if (exp_wr.size() == 0) begin
            n_fail++;
            $display("FAIL wr_strobe unexpected: got addr=%0d data=%h, required none", wr_addr,
                     wr_data);
         end else begin
            wr_t e;
            e = exp_wr.pop_front();
            if (wr_addr !== e.a || wr_data !== e.d) begin
               n_fail++;
               $display("FAIL wr_strobe: got addr=%0d data=%h, required addr=%0d data=%h",
                        wr_addr, wr_data, e.a, e.d);
            end
         end
      end
      if (!sda_t) pulled = 1'b1;
   end

   function automatic logic [63:0] model_flat();
      logic [63:0] r;
      for (int i = 0; i < 8; i++) r[8*i +: 8] = m_regs[i];
      return r;
   endfunction

   task automatic model_write(input logic [7:0] d);
      wr_t e;
      e.a = m_ptr;
      e.d = d;
      exp_wr.push_back(e);
      m_regs[m_ptr] = d;
      m_ptr = m_ptr + 3'd1;
   endtask

   task automatic bus_bit(input logic b, output logic r);
      sda_m = b;
      #(Q);
      scl_m = 1'b1;
      #(Q);
      r = sda_bus;
      #(Q);
      scl_m = 1'b0;
      #(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      #(Q);
      scl_m = 1'b1;
      #(Q);
      sda_m = 1'b0;
      #(Q);
      scl_m = 1'b0;
      #(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      #(Q);
      scl_m = 1'b1;
      #(Q);
      sda_m = 1'b1;
      #(Q);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      logic r;
      for (int i = 7; i >= 0; i--) bus_bit(b[i], r);
      bus_bit(1'b1, ack);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] b);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(1'b1, r);
         b[i] = r;
      end
      bus_bit(mack, r);
   endtask

   task automatic test_reset();
      n_checks++;
      if (sda_t !== 1'b1 || scl_t !== 1'b1 || sda_o !== 1'b0 || scl_o !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_pins: got sda_t=%b scl_t=%b sda_o=%b scl_o=%b, required 1 1 0 0",
                  sda_t, scl_t, sda_o, scl_o);
      end
      n_checks++;
      if (wr_valid !== 1'b0 || wr_addr !== 3'd0 || wr_data !== 8'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: got wr_valid=%b wr_addr=%0d wr_data=%h busy=%b, required 0",
                  wr_valid, wr_addr, wr_data, busy);
      end
      n_checks++;
      if (regs !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got %h, required 0", regs);
      end
   endtask

   task automatic test_write();
      logic [7:0] seq[4];
      logic       ack;
      seq = '{8'hA8, 8'h02, 8'h11, 8'h22};
      i2c_start();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) m_ptr = seq[i][2:0];
         else if (i > 1) model_write(seq[i]);
         write_byte(seq[i], ack);
         n_checks++;
         if (ack !== IIC_ACK) begin
            n_fail++;
            $display("FAIL write_ack byte %0d: got %b, required 0", i, ack);
         end
         if (i == 0) begin
            n_checks++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_after_ack: got %b, required 1", busy);
            end
         end
      end
      i2c_stop();
      #(Q);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_after_stop: got %b, required 0", busy);
      end
      n_checks++;
      if (regs !== model_flat()) begin
         n_fail++;
         $display("FAIL write_regs: got %h, required %h", regs, model_flat());
      end
   endtask

   task automatic test_wrong_addr();
      logic [7:0] seq[2];
      logic       ack;
      seq = '{8'hA0, 8'h55};
      pulled = 1'b0;
      i2c_start();
      for (int i = 0; i < 2; i++) begin
         write_byte(seq[i], ack);
         n_checks++;
         if (ack !== IIC_NACK) begin
            n_fail++;
            $display("FAIL wrong_addr_nack byte %0d: got %b, required 1", i, ack);
         end
      end
      i2c_stop();
      #(Q);
      n_checks++;
      if (pulled !== 1'b0 || regs !== model_flat()) begin
         n_fail++;
         $display("FAIL wrong_addr_quiet: got pulled=%b regs=%h, required 0 %h", pulled, regs,
                  model_flat());
      end
   endtask

   task automatic test_read_wrap();
      logic       ack;
      logic [7:0] b, e;
      logic [7:0] pre[3];
      pre = '{8'hC7, 8'hD0, 8'hE1};
      i2c_start();
      write_byte(8'hA8, ack);
      m_ptr = 3'd7;
      write_byte(8'h07, ack);
      for (int i = 0; i < 3; i++) begin
         model_write(pre[i]);
         write_byte(pre[i], ack);
      end
      i2c_stop();
      n_checks++;
      if (regs !== model_flat()) begin
         n_fail++;
         $display("FAIL preload_regs: got %h, required %h", regs, model_flat());
      end
      i2c_start();
      write_byte(8'hA8, ack);
      m_ptr = 3'd7;
      write_byte(8'h07, ack);
      i2c_start();
      write_byte(8'hA9, ack);
      n_checks++;
      if (ack !== IIC_ACK) begin
         n_fail++;
         $display("FAIL read_addr_ack: got %b, required 0", ack);
      end
      for (int i = 0; i < 3; i++) begin
         exp_rd.push_back(m_regs[m_ptr]);
         m_ptr = m_ptr + 3'd1;
         read_byte((i == 2) ? IIC_NACK : IIC_ACK, b);
         e = exp_rd.pop_front();
         n_checks++;
         if (b !== e) begin
            n_fail++;
            $display("FAIL read_data byte %0d: got %h, required %h", i, b, e);
         end
      end
      i2c_stop();
      n_checks++;
      if (dut.ptr_q !== m_ptr) begin
         n_fail++;
         $display("FAIL read_ptr: got %0d, required %0d", dut.ptr_q, m_ptr);
      end
      // Current-address read continues from the persisted pointer.
      i2c_start();
      write_byte(8'hA9, ack);
      exp_rd.push_back(m_regs[m_ptr]);
      m_ptr = m_ptr + 3'd1;
      read_byte(IIC_NACK, b);
      e = exp_rd.pop_front();
      n_checks++;
      if (b !== e) begin
         n_fail++;
         $display("FAIL read_current: got %h, required %h", b, e);
      end
      i2c_stop();
   endtask

   task automatic test_abort();
      logic       ack, r;
      logic [7:0] part;
      part = 8'h99;
      i2c_start();
      write_byte(8'hA8, ack);
      m_ptr = 3'd4;
      write_byte(8'h04, ack);
      for (int i = 7; i >= 3; i--) bus_bit(part[i], r);
      i2c_stop();
      #(Q);
      n_checks++;
      if (dut.state_q !== IDLE || sda_t !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got state=%0d sda_t=%b busy=%b, required IDLE 1 0",
                  dut.state_q, sda_t, busy);
      end
      n_checks++;
      if (regs !== model_flat() || dut.ptr_q !== m_ptr) begin
         n_fail++;
         $display("FAIL abort_regs: got regs=%h ptr=%0d, required %h %0d", regs, dut.ptr_q,
                  model_flat(), m_ptr);
      end
   endtask

   task automatic test_reset_mid_ack();
      logic       r, ack;
      logic [7:0] a;
      logic [7:0] seq[2];
      a = 8'hA8;
      i2c_start();
      for (int i = 7; i >= 0; i--) bus_bit(a[i], r);
      n_checks++;
      if (sda_t !== 1'b0) begin
         n_fail++;
         $display("FAIL ack_hold: got sda_t=%b, required 0", sda_t);
      end
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      n_checks++;
      if (sda_t !== 1'b1 || regs !== 64'd0) begin
         n_fail++;
         $display("FAIL async_reset: got sda_t=%b regs=%h, required 1 0", sda_t, regs);
      end
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      m_ptr = 3'd0;
      i2c_stop();
      #(Q);
      reset = 1'b1;
      #(Q);
      seq = '{8'h03, 8'h5A};
      i2c_start();
      write_byte(8'hA8, ack);
      n_checks++;
      if (ack !== IIC_ACK) begin
         n_fail++;
         $display("FAIL post_reset_ack: got %b, required 0", ack);
      end
      m_ptr = seq[0][2:0];
      write_byte(seq[0], ack);
      model_write(seq[1]);
      write_byte(seq[1], ack);
      i2c_stop();
      n_checks++;
      if (regs !== model_flat()) begin
         n_fail++;
         $display("FAIL post_reset_regs: got %h, required %h", regs, model_flat());
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] seq[4];
      logic       ack;
      int         nacks;
      seq = '{8'hA8, 8'h09, 8'h0A, 8'h0B};
      nacks = 0;
      i2c_start();
      for (int i = 0; i < 4; i++) begin
         if (i == 1) m_ptr = seq[i][2:0];
         else if (i > 1) model_write(seq[i]);
         write_byte(seq[i], ack);
         if (ack !== IIC_ACK) nacks++;
      end
      i2c_stop();
      #(Q);
      n_checks++;
      if (nacks != 0) begin
         n_fail++;
         $display("FAIL b2b_acks: got %0d NACKed bytes, required 0", nacks);
      end
      n_checks++;
      if (regs[15:8] !== 8'h0A || regs[23:16] !== 8'h0B || regs !== model_flat()) begin
         n_fail++;
         $display("FAIL b2b_regs: got %h, required %h", regs, model_flat());
      end
      n_checks++;
      if (exp_wr.size() != 0) begin
         n_fail++;
         $display("FAIL wr_drain: got %0d pending strobes, required 0", exp_wr.size());
      end
   endtask

   initial begin
      reset  = 1'b0;
      scl_m  = 1'b1;
      sda_m  = 1'b1;
      pulled = 1'b0;
      m_ptr  = 3'd0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'd0;
      #52;
      test_reset();
      #48;
      reset = 1'b1;
      #100;
      test_write();
      test_wrong_addr();
      test_read_wrap();
      test_abort();
      test_reset_mid_ack();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iic_slave_regs.md
Name: iic_slave_regs

Overview:
Synthesizable I2C target (slave) that answers iic_core transactions on the shared open-drain SCL/SDA bus.
- Decodes START, STOP and repeated START.
- ACKs its own 7-bit address and exposes an NREG-byte register bank.
- Write transfer: first byte sets the register pointer, following bytes are stored.
- Read transfer: returns bytes from the pointer.
- Sits downstream of iic_core on the bus. It is the closed-loop responder in iic_core system benches and also ships in FPGA designs.

Parameters:
SLAVE_ADDR, 7'h54, 7-bit target address (write address byte 8'hA8, read address byte 8'hA9).
NREG, 8, number of byte registers; power of two, 2..256.
PW, $clog2(NREG), register pointer width (derived; do not override).

Ports:
clk  in  1  system clock, at least 16x the SCL rate
reset  in  1  asynchronous, active-low reset
scl_i  in  1  SCL from bus, asynchronous
sda_i  in  1  SDA from bus, asynchronous
scl_o  out  1  tied 0
scl_t  out  1  tied 1; SCL is never driven (no clock stretching)
sda_o  out  1  tied 0
sda_t  out  1  0 = pull SDA low, 1 = release
wr_valid  out  1  one-cycle strobe per stored data byte
wr_addr  out  PW  register index written
wr_data  out  8  byte written
regs  out  NREG*8  register bank contents; byte i at [8i+7:8i]
busy  out  1  high from our address ACK until STOP/START

Behaviour:
Reset values and reset handling
- While reset=0, asynchronously: sda_t=1, wr_valid=0, wr_addr=0, wr_data=0, regs=0, busy=0, pointer=0, state=IDLE.
- Reset asserted mid-transfer releases SDA in the same instant, with no clock edge needed.

Input conditioning
- scl_i and sda_i pass through 2-flop synchronizers, then a third stage for edge detection.
- Events, one cycle each: scl_rise, scl_fall, start (SDA falls while SCL high), stop (SDA rises while SCL high).
- Event latency from pin: 3 clk.

Bit handling
- SDA is sampled on scl_rise.
- SDA drive changes only on scl_fall, never while SCL is high.

START and STOP handling
- start from any state: enter ADDR, bit counter=0, release SDA, busy=0. This covers repeated START.
- stop from any state: enter IDLE, release SDA, busy=0.
- A partially received byte is discarded: no wr_valid and no pointer change.
- Pointer value persists across transactions.

States
- IDLE: wait for start.
- ADDR: shift 8 bits MSB-first. On the 8th scl_fall:
  - match → ADDR_ACK with SDA pulled low;
  - otherwise → IGNORE.
- ADDR_ACK: hold the ACK low through the ack clock. On the next scl_fall, busy=1, then:
  - R/W=0 → WR_DATA with SDA released, first-byte flag set;
  - R/W=1 → RD_DATA, loading shift register from regs[pointer] and driving its MSB.
- WR_DATA: shift 8 bits. On the 8th scl_fall → WR_ACK, pull SDA low.
  - First byte after address: pointer = byte mod NREG.
  - Later bytes: regs[pointer]=byte; wr_valid=1 with wr_addr=pointer, wr_data=byte; then pointer increments mod NREG.
  - regs update in the same cycle as wr_valid.
- WR_ACK: on scl_fall release SDA → WR_DATA. Every byte is ACKed, no buffer-full NACK.
- RD_DATA: on each scl_fall drive the next bit (sda_t=bit, so 1 releases SDA). After the 8th bit's scl_fall, release SDA → RD_ACK and increment pointer mod NREG.
- RD_ACK: sample the master's ACK on scl_rise.
  - ACK (0): on scl_fall load regs[pointer] and drive its MSB → RD_DATA.
  - NACK (1): → IGNORE with SDA released.
- IGNORE: SDA released; wait for start or stop.

Boundary conditions
- Pointer wraps NREG-1 → 0 on both reads and writes.
- Pointer byte ≥ NREG is truncated to its low PW bits.
- A general-call address (0x00) is not ACKed.
- Simultaneous start and scl_fall cannot occur: start requires SCL high.
- If stop and start both assert in one cycle (glitch), start wins.

Decomposition:
- Package iic_pkg holds:
  - state enum iic_slv_state_t (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE);
  - constants IIC_RW_WRITE=0, IIC_RW_READ=1, IIC_ACK=0, IIC_NACK=1.
- Sub-module iic_bus_monitor (synchronizers plus scl_rise, scl_fall, start, stop detection) is shared with iic_core and future bus snoopers.

Test Plan:
- Write: START, A8, 02, 11, 22, STOP → all four bytes ACKed; wr_valid pulses (2,11) then (3,22); regs[2]=11, regs[3]=22; busy low after STOP.
- Wrong address: START, A0, 55, STOP → SDA never pulled low by the slave (NACK); regs unchanged; no wr_valid.
- Read with wrap: preload regs[7]=C7, regs[0]=D0, regs[1]=E1. Send START, A8, 07, repeated START, A9, read 3 bytes (master ACK, ACK, NACK), STOP → returns C7, D0, E1; pointer ends at 2.
- Abort mid-byte: START, A8, 04, 5 bits of 0x99, STOP → no wr_valid; regs[4] unchanged; state IDLE; SDA released.
- Reset mid-ACK: assert reset while the slave holds SDA low during ADDR_ACK → sda_t=1 immediately; regs=0; after release, a fresh A8 transaction is ACKed.
- Closed loop with iic_core: write A8, 09, 0A, 0B via iic_core's TX FIFO → slave ACKs all; regs[1]=0A, regs[2]=0B (pointer 09 mod 8 = 1).
